// File: rtl/mul_seq_if.sv
// Request/response bundle of the sequential multiplier: operands and start in,
// busy/done status and the double-width product out.
interface mul_seq_if #(
  parameter int BUS_WIDTH = 16
);
  logic                   start;
  logic [BUS_WIDTH-1:0]   a;
  logic [BUS_WIDTH-1:0]   b;
  logic                   busy;
  logic                   done;
  logic [2*BUS_WIDTH-1:0] product;

  modport master (
    output start, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, a, b,
    output busy, done, product
  );
endinterface

// File: rtl/mul_seq.sv
// Unsigned shift-and-add multiplier: one ripple adder, one iteration per cycle.
// Optional early termination when the remaining multiplier bits are zero: MUL_SEQ_EARLY_EXIT_EN.

module add #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);
  always_comb begin
    logic c;
    // NOTE: blocking assignments in combinational logic; the carry must ripple bit to bit in one evaluation.
    c     = cin_i;
    sum_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c;
      c        = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
    end
    cout_o = c;
  end
endmodule

module mul_seq #(
  parameter int BUS_WIDTH = 16
) (
  input  logic     clk,
  input  logic     reset,
  mul_seq_if.slave bus
);
  localparam int              CW        = $clog2(BUS_WIDTH + 1);
  localparam logic [CW-1:0]   LAST_ITER = CW'(BUS_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e                 state_q,   state_d;
  logic [BUS_WIDTH-1:0]   mcand_q,   mcand_d;
  logic [BUS_WIDTH-1:0]   mplier_q,  mplier_d;
  logic [BUS_WIDTH-1:0]   acc_hi_q,  acc_hi_d;
  logic [BUS_WIDTH-1:0]   acc_lo_q,  acc_lo_d;
  logic [CW-1:0]          count_q,   count_d;
  logic [2*BUS_WIDTH-1:0] product_q, product_d;

  logic                   accept;
  logic                   last_iter;
  logic [BUS_WIDTH-1:0]   partial;
  logic [BUS_WIDTH-1:0]   psum;
  logic                   carry;
  logic [2*BUS_WIDTH-1:0] acc_next;
  logic                   busy;
  logic                   done;

  assign accept  = bus.start && (state_q != S_RUN);
  assign partial = mcand_q & {BUS_WIDTH{mplier_q[0]}};

  add #(.WIDTH(BUS_WIDTH)) u_add (
    .a_i    (acc_hi_q),
    .b_i    (partial),
    .cin_i  (1'b0),
    .sum_o  (psum),
    .cout_o (carry)
  );

  // The adder carry becomes the new MSB; the LSB of acc_lo drops off the bottom.
  assign acc_next = (2*BUS_WIDTH)'({carry, psum, acc_lo_q} >> 1);

`ifdef MUL_SEQ_EARLY_EXIT_EN
  logic [CW-1:0] remaining;
  logic          mplier_empty;

  // Once the shifted multiplier is zero every later iteration only shifts.
  assign mplier_empty = (mplier_q[BUS_WIDTH-1:1] == '0);
  assign remaining    = LAST_ITER - count_q;
  assign last_iter    = (count_q == LAST_ITER) || mplier_empty;
`else
  assign last_iter    = (count_q == LAST_ITER);
`endif

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_RUN;
      S_RUN:   if (last_iter) state_d = S_DONE;
      S_DONE:  state_d = bus.start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      S_RUN:   busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.product = product_q;

  always_comb begin
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    count_d   = count_q;
    product_d = product_q;
    if (accept) begin
      mcand_d  = bus.a;
      mplier_d = bus.b;
      acc_hi_d = '0;
      acc_lo_d = '0;
      count_d  = '0;
    end else if (state_q == S_RUN) begin
      acc_hi_d = acc_next[2*BUS_WIDTH-1:BUS_WIDTH];
      acc_lo_d = acc_next[BUS_WIDTH-1:0];
      mplier_d = mplier_q >> 1;
      count_d  = count_q + CW'(1);
      if (last_iter) begin
`ifdef MUL_SEQ_EARLY_EXIT_EN
        product_d = acc_next >> remaining;
`else
        product_d = acc_next;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end
endmodule
